// File: rtl/data_ram_arbiter_if.sv
// Request/grant/read-return bundle shared by the CPU bus path, the debug
// monitor port and DATA_RAM, as seen from the arbiter (slave) or requesters (master).
interface data_ram_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              i_cpu_req;
    logic              i_cpu_we;
    logic [ADDR_W-1:0] i_cpu_addr;
    logic [DATA_W-1:0] i_cpu_wdata;
    logic              o_cpu_gnt;
    logic              o_cpu_rvalid;

    logic              i_dbg_en;
    logic              i_dbg_req;
    logic              i_dbg_we;
    logic [ADDR_W-1:0] i_dbg_addr;
    logic [DATA_W-1:0] i_dbg_wdata;
    logic              o_dbg_gnt;
    logic              o_dbg_rvalid;

    logic [DATA_W-1:0] o_rdata;
    logic              o_ram_read;
    logic              o_ram_write;
    logic [ADDR_W-1:0] o_ram_addr;
    logic [DATA_W-1:0] o_ram_wdata;
    logic [DATA_W-1:0] i_ram_rdata;
    logic              o_busy;

    modport slave (
        input  i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
        input  i_dbg_en, i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
        input  i_ram_rdata,
        output o_cpu_gnt, o_cpu_rvalid, o_dbg_gnt, o_dbg_rvalid,
        output o_rdata, o_ram_read, o_ram_write, o_ram_addr, o_ram_wdata, o_busy
    );

    modport master (
        output i_cpu_req, i_cpu_we, i_cpu_addr, i_cpu_wdata,
        output i_dbg_en, i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata,
        output i_ram_rdata,
        input  o_cpu_gnt, o_cpu_rvalid, o_dbg_gnt, o_dbg_rvalid,
        input  o_rdata, o_ram_read, o_ram_write, o_ram_addr, o_ram_wdata, o_busy
    );
endinterface

// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter sharing single-port DATA_RAM between the CPU bus path and
// the debug monitor; registered RAM command, read data routed back to its issuer.
module data_ram_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic               i_clk,
    input  logic               i_rst,
    data_ram_arbiter_if.slave  bus
);
    localparam int CPU = 0;
    localparam int DBG = 1;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_DBG = 1'b1
    } owner_t;

    logic [1:0]        req;
    logic [1:0]        we;
    logic [ADDR_W-1:0] addr  [2];
    logic [DATA_W-1:0] wdata [2];
    logic [1:0]        elig;
    logic [1:0]        win;
    logic              sel;

    logic [1:0]        gnt_q, gnt_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic              ram_read_q, ram_read_d;
    logic              ram_write_q, ram_write_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    owner_t            last_owner_q, last_owner_d;

    assign req         = {bus.i_dbg_en & bus.i_dbg_req, bus.i_cpu_req};
    assign we          = {bus.i_dbg_we, bus.i_cpu_we};
    assign addr[CPU]   = bus.i_cpu_addr;
    assign addr[DBG]   = bus.i_dbg_addr;
    assign wdata[CPU]  = bus.i_cpu_wdata;
    assign wdata[DBG]  = bus.i_dbg_wdata;

    // A master holding its grant this cycle sits out; its rvalid follows a read grant.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_master
            assign elig[gi]     = req[gi] & ~gnt_q[gi];
            assign rvalid_d[gi] = gnt_q[gi] & ram_read_q;
        end
    endgenerate

    assign win[CPU] = elig[CPU] & (~elig[DBG] | (last_owner_q == OWN_DBG));
    assign win[DBG] = elig[DBG] & ~win[CPU];
    assign sel      = win[DBG];

    always_comb begin
        gnt_d        = win;
        ram_read_d   = 1'b0;
        ram_write_d  = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        last_owner_d = last_owner_q;
        if (|win) begin
            ram_read_d   = ~we[sel];
            ram_write_d  = we[sel];
            ram_addr_d   = addr[sel];
            ram_wdata_d  = we[sel] ? wdata[sel] : '0;
            last_owner_d = win[DBG] ? OWN_DBG : OWN_CPU;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            gnt_q        <= '0;
            rvalid_q     <= '0;
            ram_read_q   <= 1'b0;
            ram_write_q  <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            last_owner_q <= OWN_DBG;
        end else begin
            gnt_q        <= gnt_d;
            rvalid_q     <= rvalid_d;
            ram_read_q   <= ram_read_d;
            ram_write_q  <= ram_write_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            last_owner_q <= last_owner_d;
        end
    end

    assign bus.o_cpu_gnt    = gnt_q[CPU];
    assign bus.o_dbg_gnt    = gnt_q[DBG];
    assign bus.o_cpu_rvalid = rvalid_q[CPU];
    assign bus.o_dbg_rvalid = rvalid_q[DBG];
    assign bus.o_ram_read   = ram_read_q;
    assign bus.o_ram_write  = ram_write_q;
    assign bus.o_ram_addr   = ram_addr_q;
    assign bus.o_ram_wdata  = ram_wdata_q;
    // RAM output is only meaningful in the cycle after a read; mask it otherwise.
    assign bus.o_rdata      = (|rvalid_q) ? bus.i_ram_rdata : '0;
    assign bus.o_busy       = (|gnt_q) | (|rvalid_q);
endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench for data_ram_arbiter: RAM model, command/read-data
// scoreboard per master, table of single accesses plus hand-written corner cases.
module tb_data_ram_arbiter;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    data_ram_arbiter_if #(.ADDR_W(8), .DATA_W(16)) bus ();
    data_ram_arbiter #(.ADDR_W(8), .DATA_W(16)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));

    typedef struct packed {
        logic        we;
        logic [7:0]  addr;
        logic [15:0] wdata;
    } cmd_t;

    typedef struct {
        bit          dbg;
        bit          we;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 1'b0;
    cmd_t        cpu_cmd_q[$];
    cmd_t        dbg_cmd_q[$];
    logic [15:0] cpu_rd_q[$];
    logic [15:0] dbg_rd_q[$];
    bit          gnt_log[$];
    logic        exp_rv_cpu = 1'b0;
    logic        exp_rv_dbg = 1'b0;

    // RAM model: registered read, initial contents C000|addr with 0x10 = 0x1234.
    logic [15:0] mem [256];
    logic [15:0] ram_rdata;
    logic        mem_loaded;
    always @(posedge clk) begin
        if (mem_loaded !== 1'b1) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'hC000 | 16'(i);
            mem[8'h10] <= 16'h1234;
            mem_loaded <= 1'b1;
            ram_rdata  <= 16'h0;
        end else begin
            if (bus.o_ram_write) mem[bus.o_ram_addr] <= bus.o_ram_wdata;
            if (bus.o_ram_read) ram_rdata <= mem[bus.o_ram_addr];
        end
    end
    assign bus.i_ram_rdata = ram_rdata;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_cmd(input string who, input cmd_t c);
        $display("txn %s %s addr=%02h wdata=%04h", who, c.we ? "WR" : "RD", c.addr, c.wdata);
        chk({who, "_ram_write"}, bus.o_ram_write, c.we);
        chk({who, "_ram_read"},  bus.o_ram_read, !c.we);
        chk({who, "_ram_addr"},  bus.o_ram_addr, c.addr);
        chk({who, "_ram_wdata"}, bus.o_ram_wdata, c.wdata);
    endtask

    task automatic check_all_zero(input string who);
        chk({who, "_gnt"},    {bus.o_cpu_gnt, bus.o_dbg_gnt}, 0);
        chk({who, "_rvalid"}, {bus.o_cpu_rvalid, bus.o_dbg_rvalid}, 0);
        chk({who, "_strobe"}, {bus.o_ram_read, bus.o_ram_write}, 0);
        chk({who, "_addr"},   bus.o_ram_addr, 0);
        chk({who, "_wdata"},  bus.o_ram_wdata, 0);
        chk({who, "_rdata"},  bus.o_rdata, 0);
        chk({who, "_busy"},   bus.o_busy, 0);
    endtask

    // Scoreboard: commands and read data queued at stimulus time, consumed on gnt/rvalid.
    always @(negedge clk) begin
        if (!mon_en) begin
            exp_rv_cpu <= 1'b0;
            exp_rv_dbg <= 1'b0;
        end else begin
            chk("one_gnt", bus.o_cpu_gnt & bus.o_dbg_gnt, 0);
            if (bus.o_cpu_gnt) begin
                gnt_log.push_back(1'b0);
                if (cpu_cmd_q.size() == 0) chk("cpu_gnt_unexpected", 1, 0);
                else check_cmd("cpu", cpu_cmd_q.pop_front());
            end
            if (bus.o_dbg_gnt) begin
                gnt_log.push_back(1'b1);
                if (dbg_cmd_q.size() == 0) chk("dbg_gnt_unexpected", 1, 0);
                else check_cmd("dbg", dbg_cmd_q.pop_front());
            end
            if (!bus.o_cpu_gnt && !bus.o_dbg_gnt)
                chk("idle_strobes", {bus.o_ram_read, bus.o_ram_write}, 0);
            chk("cpu_rvalid", bus.o_cpu_rvalid, exp_rv_cpu);
            chk("dbg_rvalid", bus.o_dbg_rvalid, exp_rv_dbg);
            if (bus.o_cpu_rvalid && cpu_rd_q.size() > 0) chk("cpu_rdata", bus.o_rdata, cpu_rd_q.pop_front());
            if (bus.o_dbg_rvalid && dbg_rd_q.size() > 0) chk("dbg_rdata", bus.o_rdata, dbg_rd_q.pop_front());
            if (!bus.o_cpu_rvalid && !bus.o_dbg_rvalid) chk("idle_rdata", bus.o_rdata, 0);
            chk("busy", bus.o_busy, bus.o_cpu_gnt | bus.o_dbg_gnt | bus.o_cpu_rvalid | bus.o_dbg_rvalid);
            exp_rv_cpu <= bus.o_cpu_gnt & ~bus.o_ram_write;
            exp_rv_dbg <= bus.o_dbg_gnt & ~bus.o_ram_write;
        end
    end

    task automatic txn(input bit d, input bit we, input logic [7:0] addr, input logic [15:0] wd,
                       input logic [15:0] exp, output int waited);
        cmd_t c;
        c.we    = we;
        c.addr  = addr;
        c.wdata = we ? wd : 16'h0;
        if (d) begin
            dbg_cmd_q.push_back(c);
            if (!we) dbg_rd_q.push_back(exp);
            bus.i_dbg_req = 1'b1; bus.i_dbg_we = we; bus.i_dbg_addr = addr; bus.i_dbg_wdata = wd;
        end else begin
            cpu_cmd_q.push_back(c);
            if (!we) cpu_rd_q.push_back(exp);
            bus.i_cpu_req = 1'b1; bus.i_cpu_we = we; bus.i_cpu_addr = addr; bus.i_cpu_wdata = wd;
        end
        waited = 0;
        do begin
            @(posedge clk); #1;
            waited++;
        end while (!(d ? bus.o_dbg_gnt : bus.o_cpu_gnt) && waited < 50);
        if (!(d ? bus.o_dbg_gnt : bus.o_cpu_gnt)) begin
            n_checks++;
            n_fail++;
            $display("FAIL txn_timeout: no grant for %s addr=%02h after %0d cycles, expected one",
                     d ? "dbg" : "cpu", addr, waited);
        end
        if (d) bus.i_dbg_req = 1'b0;
        else   bus.i_cpu_req = 1'b0;
    endtask

    vec_t vecs [10];
    int   w1, w2;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{1'b0, 1'b0, 8'h10, 16'hFFFF, 16'h1234};
        vecs[1] = '{1'b1, 1'b1, 8'hFF, 16'h5A5A, 16'h0000};
        vecs[2] = '{1'b1, 1'b0, 8'hFF, 16'hFFFF, 16'h5A5A};
        vecs[3] = '{1'b0, 1'b1, 8'h00, 16'hBEEF, 16'h0000};
        vecs[4] = '{1'b1, 1'b0, 8'h00, 16'h1111, 16'hBEEF};
        vecs[5] = '{1'b0, 1'b0, 8'hFF, 16'h2222, 16'h5A5A};
        vecs[6] = '{1'b1, 1'b1, 8'h7F, 16'h0001, 16'h0000};
        vecs[7] = '{1'b0, 1'b0, 8'h7F, 16'h3333, 16'h0001};
        vecs[8] = '{1'b0, 1'b0, 8'h01, 16'h4444, 16'hAAAA};
        vecs[9] = '{1'b1, 1'b0, 8'h80, 16'h5555, 16'hC080};

        rst = 1'b1;
        bus.i_cpu_req = 1'b0; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = '0; bus.i_cpu_wdata = '0;
        bus.i_dbg_en  = 1'b1; bus.i_dbg_req = 1'b0; bus.i_dbg_we = 1'b0;
        bus.i_dbg_addr = '0;  bus.i_dbg_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        mon_en = 1'b1;

        // Both request through reset: CPU write wins the first tie, debug read sees it.
        fork
            txn(1'b0, 1'b1, 8'h01, 16'hAAAA, 16'h0000, w1);
            txn(1'b1, 1'b0, 8'h01, 16'h0F0F, 16'hAAAA, w2);
            begin repeat (2) @(posedge clk); #1; rst = 1'b0; end
        join
        repeat (3) @(posedge clk);
        #1;
        if (gnt_log.size() < 2) chk("tie_grant_count", gnt_log.size(), 2);
        else begin
            chk("tie_first_cpu", gnt_log[0], 0);
            chk("tie_second_dbg", gnt_log[1], 1);
        end

        for (int i = 0; i < 10; i++) begin
            txn(vecs[i].dbg, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, w1);
            chk("tbl_gnt_latency", w1, 1);
            @(posedge clk); #1;
        end
        repeat (2) @(posedge clk);
        #1;

        // Debug request masked by i_dbg_en, then released.
        dbg_cmd_q.push_back('{1'b0, 8'h33, 16'h0});
        dbg_rd_q.push_back(16'hC033);
        bus.i_dbg_en = 1'b0; bus.i_dbg_req = 1'b1; bus.i_dbg_we = 1'b0;
        bus.i_dbg_addr = 8'h33; bus.i_dbg_wdata = 16'h1111;
        repeat (10) begin
            @(posedge clk); #1;
            chk("dben_no_gnt", bus.o_dbg_gnt, 0);
            chk("dben_no_strobe", {bus.o_ram_read, bus.o_ram_write}, 0);
        end
        bus.i_dbg_en = 1'b1;
        @(posedge clk); #1;
        chk("dben_gnt", bus.o_dbg_gnt, 1);
        bus.i_dbg_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Reset in the cycle a CPU read grant is issued.
        mon_en = 1'b0;
        bus.i_cpu_req = 1'b1; bus.i_cpu_we = 1'b0; bus.i_cpu_addr = 8'h10; bus.i_cpu_wdata = 16'h0;
        @(posedge clk); #1;
        chk("rstg_cpu_gnt", bus.o_cpu_gnt, 1);
        chk("rstg_ram_read", bus.o_ram_read, 1);
        rst = 1'b1;
        bus.i_dbg_req = 1'b1; bus.i_dbg_we = 1'b0; bus.i_dbg_addr = 8'h11;
        @(posedge clk); #1;
        check_all_zero("rstg");
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstg_tie_cpu", bus.o_cpu_gnt, 1);
        chk("rstg_tie_no_dbg", bus.o_dbg_gnt, 0);
        chk("rstg_no_rvalid", bus.o_cpu_rvalid, 0);
        bus.i_cpu_req = 1'b0;
        @(posedge clk); #1;
        chk("rstg_dbg_gnt", bus.o_dbg_gnt, 1);
        chk("rstg_cpu_rvalid", bus.o_cpu_rvalid, 1);
        chk("rstg_cpu_rdata", bus.o_rdata, 16'h1234);
        bus.i_dbg_req = 1'b0;
        @(posedge clk); #1;
        chk("rstg_dbg_rvalid", {bus.o_cpu_rvalid, bus.o_dbg_rvalid}, 2'b01);
        chk("rstg_dbg_rdata", bus.o_rdata, 16'hC011);
        repeat (2) @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Both masters stream six accesses each; grants must alternate strictly.
        gnt_log.delete();
        fork
            for (int k = 0; k < 6; k++) txn(1'b0, 1'b1, 8'(8'h20 + k), 16'(16'h2000 + k), 16'h0, w1);
            for (int k = 0; k < 6; k++) txn(1'b1, 1'b0, 8'(8'h40 + k), 16'hFFFF, 16'(16'hC040 + k), w2);
        join
        repeat (4) @(posedge clk);
        #1;
        begin
            int ncpu = 0;
            int viol = 0;
            for (int k = 0; k < gnt_log.size(); k++) begin
                if (gnt_log[k] == 1'b0) ncpu++;
                if (k > 0 && gnt_log[k] == gnt_log[k-1]) viol++;
            end
            chk("alt_total", gnt_log.size(), 12);
            chk("alt_cpu_count", ncpu, 6);
            chk("alt_no_repeat", viol, 0);
        end

        chk("cpu_cmd_drained", cpu_cmd_q.size() + cpu_rd_q.size(), 0);
        chk("dbg_cmd_drained", dbg_cmd_q.size() + dbg_rd_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/data_ram_arbiter.md
# data_ram_arbiter

Two-port arbiter sharing the single-port DATA_RAM between the CPU external-bus path (MAR/MBR traffic) and a debug monitor port used by the user interface to inspect or patch data memory. It accepts held-level requests from both masters, picks one per cycle with round-robin fairness, and drives a registered RAM command. It returns read data, one cycle after the command, to the master that issued it. It sits between EXTERNAL_BUS/user-interface logic and DATA_RAM.

## Interface
- ADDR_W, 8, RAM address width
- DATA_W, 16, RAM data width

- i_clk  in  1  system clock; all logic on rising edge
- i_rst  in  1  reset, synchronous, active-high
- i_cpu_req  in  1  CPU access request, held until o_cpu_gnt
- i_cpu_we  in  1  CPU write (1) / read (0), stable while req high
- i_cpu_addr  in  ADDR_W  CPU address
- i_cpu_wdata  in  DATA_W  CPU write data
- o_cpu_gnt  out  1  one-cycle grant pulse to CPU
- o_cpu_rvalid  out  1  one-cycle CPU read-data valid
- i_dbg_en  in  1  debug port enable; 0 masks i_dbg_req
- i_dbg_req, i_dbg_we, i_dbg_addr, i_dbg_wdata  in  1/1/ADDR_W/DATA_W  debug request, same rules as CPU
- o_dbg_gnt  out  1  one-cycle grant pulse to debug
- o_dbg_rvalid  out  1  one-cycle debug read-data valid
- o_rdata  out  DATA_W  read data, valid only with an rvalid
- o_ram_read  out  1  RAM read strobe
- o_ram_write  out  1  RAM write strobe
- o_ram_addr  out  ADDR_W  RAM address
- o_ram_wdata  out  DATA_W  RAM write data
- i_ram_rdata  in  DATA_W  RAM read data, registered in RAM, valid cycle after o_ram_read
- o_busy  out  1  command or read return in flight

## Operation
- Eligibility at edge T: CPU eligible = i_cpu_req & !o_cpu_gnt. Debug eligible = i_dbg_en & i_dbg_req & !o_dbg_gnt. A master is never re-granted in the cycle its grant is high, so requesters drop req on seeing gnt.
- Selection:
  - One eligible master: it wins.
  - Both eligible: winner is the master not recorded in last_owner.
  - last_owner resets to DBG, so CPU wins the first tie.
  - last_owner updates only on a grant.
- Grant: at T+1, winner's gnt = 1 and the registered RAM command is driven for exactly that cycle:
  - o_ram_write = we.
  - o_ram_read = !we.
  - o_ram_addr / o_ram_wdata copied from the winner.
  - o_ram_wdata = 0 on reads.
- Read return: for a read granted at T+1, the RAM presents data at T+2. The block drives o_rdata = i_ram_rdata combinationally while the owner's rvalid (registered, tagged with owner) is high at T+2. Writes produce no rvalid.
- Pipelining: a new grant may occur at T+2 while the previous read returns. At most one command and one return in flight. Neither rvalid line ever asserts for a master that did not issue the read.
- o_busy = any gnt | any rvalid.
- Idle: gnt, RAM strobes and rvalids 0. o_ram_addr/o_ram_wdata hold their last value. o_rdata = 0 when no rvalid.
- i_dbg_en falling while debug is pending: no further debug grant. A debug grant or rvalid already registered still completes.

## Timing
- Reset (i_rst high at an edge):
  - All outputs 0: gnt, rvalid, strobes, addr, wdata, o_rdata, o_busy.
  - last_owner = DBG.
  - In-flight command or return is discarded; no rvalid after reset.
  - Requests sampled in the reset cycle are ignored.
- Latency: req sampled at edge T → gnt/RAM command at T+1 → rvalid/data at T+2.
- Throughput: one access per cycle overall. A single master gets at most one grant every 2 cycles. Both masters continuously requesting alternate CPU, DBG, CPU, …
- Simultaneous CPU write and debug read to the same address, CPU winning: the write is committed first, and the debug read at the next grant returns the new value.
- Address wrap is not applicable: addresses pass through unmodified, full ADDR_W range.

## Test plan
- Reset then single CPU read addr 0x10, RAM holds 0x1234: o_cpu_gnt at T+1, o_ram_read=1, o_ram_addr=0x10; o_cpu_rvalid=1, o_rdata=0x1234 at T+2; o_dbg_rvalid stays 0.
- Both masters hold req from reset, CPU writes 0xAAAA@0x01, debug reads 0x01: CPU granted first, debug next eligible cycle; debug rvalid returns 0xAAAA.
- Both continuously request 6 accesses each: grants alternate strictly CPU/DBG; each master receives 6 grants; no master is granted two cycles in a row.
- i_dbg_en=0 with i_dbg_req=1 for 10 cycles while CPU idle: no o_dbg_gnt, no RAM strobe; raise i_dbg_en → o_dbg_gnt one cycle after sampling.
- Assert i_rst in the cycle a CPU read grant is issued: next cycle all outputs 0, no o_cpu_rvalid; post-reset tie grants CPU first.
- Debug write 0x5A5A@0xFF then debug read 0xFF: write strobe with addr 0xFF, no rvalid; read returns 0x5A5A with o_dbg_rvalid.
